mic_frame_buffer: RTL and testbench
===================================

# mic_frame_buffer

Parametrised framing stage between the microphone sample stream and the FFT/histogram path. Writes every valid mic sample into a circular buffer and, every HOP samples once FRAME_LEN samples exist, emits one frame as an indexed sample stream under a valid/ready handshake. Successor to the fixed 16-sample capture: frame length, sample width and hop (overlap) are parameters, the consumer may stall, and dropped or corrupted frames are flagged.

## Interface
- SAMPLE_W, 16: mic sample width in bits.
- FRAME_LEN, 16: samples per frame; power of two, 4..256.
- HOP, FRAME_LEN: new samples between frame boundaries; 1..FRAME_LEN (HOP < FRAME_LEN gives overlapping frames).
- clk  in  1: single clock, all logic on posedge.
- rst_n  in  1: synchronous, active-low reset.
- mic_valid  in  1: mic_sample valid this cycle.
- mic_sample  in  SAMPLE_W: signed mic sample.
- out_valid  out  1: out_data/out_idx/out_last/out_corrupt valid.
- out_ready  in  1: consumer accepts the beat when out_valid & out_ready.
- out_data  out  SAMPLE_W: frame sample, oldest first.
- out_idx  out  log2(FRAME_LEN): index of sample within frame, 0..FRAME_LEN-1.
- out_last  out  1: high on beat with out_idx = FRAME_LEN-1.
- out_corrupt  out  1: on last beat only; 1 if any sample of this frame was overwritten before it was read.
- overrun  out  1: one-cycle pulse when a frame boundary is dropped.
- overrun_cnt  out  16: dropped-boundary count (see Configuration).

## Operation
- Storage: circular RAM, depth 2*FRAME_LEN, SAMPLE_W wide; write pointer wp (log2(2*FRAME_LEN) bits, wraps naturally) increments on every mic_valid. Writes never stall.
- Fill counter counts accepted samples to FRAME_LEN, saturating; after saturation a hop counter counts 0..HOP-1, wrapping.
- Frame boundary: the write completing FRAME_LEN samples after reset, then every HOP-th write after. Frame start address = wp_after_write - FRAME_LEN (mod 2*FRAME_LEN).
- States: IDLE -> (boundary) LOAD -> STREAM -> (last beat accepted) IDLE; also STREAM -> LOAD directly if a boundary was latched as pending.
- One pending slot: a boundary arriving during LOAD/STREAM latches start address into pending if empty; if pending is already full, the boundary is dropped, overrun pulses, pending keeps the older address.
- LOAD: issue RAM read of start address; STREAM: present registered sample, advance read address on each accepted beat; out_valid held with data stable while out_ready low.
- Corruption: during STREAM, a write to an address of the current frame not yet accepted sets a sticky corrupt bit, reported on out_last beat, cleared on entering LOAD.
- Simultaneous boundary and last-beat accept: boundary goes to pending (slot freed same cycle counts as empty); next state LOAD.
- Arithmetic: all address math mod 2*FRAME_LEN; out_idx wraps to 0 after last.

## Timing
- Reset (rst_n low at posedge): wp, counters, pending, corrupt = 0; state IDLE; out_valid, out_data, out_idx, out_last, out_corrupt, overrun, overrun_cnt = 0. Buffer contents not cleared.
- Reset mid-frame: stream aborts with no further beats; fill restarts from 0.
- Latency: boundary write at cycle T -> LOAD at T+1 -> out_valid first beat at T+2.
- Throughput: one beat per cycle with out_ready held high; frame takes FRAME_LEN cycles.
- Back-to-back frames: one idle (LOAD) cycle between out_last accept and next frame's first beat.
- Data integrity guaranteed only if a frame is fully read within FRAME_LEN input samples of its boundary; otherwise out_corrupt.

## Configuration
- MIC_FRAME_OVERRUN_CNT_EN defined: overrun_cnt counts overrun pulses, saturating at 16'hFFFF, cleared only by reset.
- Not defined: counter logic absent, overrun_cnt tied to 0; overrun pulse still present.

## Test plan
- FRAME_LEN=16, HOP=16, mic_valid=1 every cycle, samples 0,1,2,...; out_ready=1 -> frames 0..15, 16..31, ...; first out_valid at cycle 2 after 16th write; out_last with out_idx=15; out_corrupt=0.
- FRAME_LEN=16, HOP=4, ramp input -> frames start at 0,4,8,...; each frame = 16 consecutive values; no overrun with out_ready=1 and mic_valid every 4th cycle.
- HOP=4, mic_valid every cycle, out_ready=1 -> boundaries outpace 17-cycle frame; overrun pulses, overrun_cnt increments (macro on) or stays 0 (macro off).
- HOP=16, out_ready held low 20 cycles after first beat, mic_valid every cycle -> data stable while stalled; frame completes with out_corrupt=1.
- Boundary on same cycle as out_last accept -> next frame first beat exactly 2 cycles later, no overrun.
- rst_n low for 1 cycle mid-STREAM -> out_valid 0 next cycle, all outputs 0; next frame only after 16 new samples.

Source files
------------

// File: rtl/mic_frame_buffer.sv
// mic_frame_buffer: writes every valid mic sample into a 2*FRAME_LEN circular
// buffer and, every HOP samples once a full frame exists, streams that frame
// oldest-first over a valid/ready handshake with index, last and corrupt flags.
// Optional dropped-boundary counter: define MIC_FRAME_OVERRUN_CNT_EN.
module mic_frame_buffer #(
  parameter int SAMPLE_W  = 16,
  parameter int FRAME_LEN = 16,
  parameter int HOP       = FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mic_valid,
  input  logic signed [SAMPLE_W-1:0]   mic_sample,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [SAMPLE_W-1:0]   out_data,
  output logic [$clog2(FRAME_LEN)-1:0] out_idx,
  output logic                         out_last,
  output logic                         out_corrupt,
  output logic                         overrun,
  output logic [15:0]                  overrun_cnt
);
  localparam int IW    = $clog2(FRAME_LEN);
  localparam int AW    = IW + 1;
  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int HW    = (HOP > 1) ? $clog2(HOP) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam logic [AW-1:0] FRAME_A  = AW'(FRAME_LEN);
  localparam logic [AW-1:0] FILL_PRE = AW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [HW-1:0] HOP_LAST = HW'(HOP - 1);

  logic [AW-1:0]              wp_q, wp_d;
  logic [AW-1:0]              fill_q, fill_d;
  logic [HW-1:0]              hop_q, hop_d;
  logic [1:0]                 state_q, state_d;
  logic [AW-1:0]              start_q, start_d;
  logic                       pend_vld_q, pend_vld_d;
  logic [AW-1:0]              pend_addr_q, pend_addr_d;
  logic                       corrupt_q, corrupt_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic [IW-1:0]              out_idx_q, out_idx_d;
  logic                       out_last_q, out_last_d;
  logic                       overrun_q, overrun_d;

  logic signed [SAMPLE_W-1:0] mem [DEPTH];

  logic [AW-1:0] wp_inc, bnd_addr, wr_off, rd_addr;
  logic [IW-1:0] nxt_idx;
  logic          bnd, accept, last_acc, wr_hit;

  // Sample storage: writes never stall and the contents survive reset.
  always_ff @(posedge clk) begin
    if (mic_valid) mem[wp_q] <= mic_sample;
  end

  // Boundary detection, handshake decode and frame-relative address math.
  always_comb begin
    wp_inc   = wp_q + 1'b1;
    bnd_addr = wp_inc - FRAME_A;
    bnd      = mic_valid && ((fill_q == FILL_PRE) ||
                             ((fill_q == FRAME_A) && (hop_q == HOP_LAST)));
    accept   = out_valid_q && out_ready;
    last_acc = (state_q == S_STREAM) && accept && out_last_q;
    nxt_idx  = out_idx_q + 1'b1;
    rd_addr  = start_q + {1'b0, nxt_idx};
    // A write landing on a frame slot at or after the presented beat hits unread data.
    wr_off   = wp_q - start_q;
    wr_hit   = mic_valid && (state_q == S_STREAM) &&
               (wr_off < FRAME_A) && (wr_off >= {1'b0, out_idx_q});
  end

  // Write pointer, fill saturation and hop counting.
  always_comb begin
    wp_d   = wp_q;
    fill_d = fill_q;
    hop_d  = hop_q;
    if (mic_valid) begin
      wp_d = wp_inc;
      if (fill_q != FRAME_A)      fill_d = fill_q + 1'b1;
      else if (hop_q == HOP_LAST) hop_d  = '0;
      else                        hop_d  = hop_q + 1'b1;
    end
  end

  // Frame FSM: single pending boundary slot, one LOAD cycle ahead of each frame.
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    corrupt_d   = corrupt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    overrun_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bnd) begin
          state_d = S_LOAD;
          start_d = bnd_addr;
        end
      end
      S_LOAD: begin
        state_d     = S_STREAM;
        out_valid_d = 1'b1;
        out_data_d  = mem[start_q];
        out_idx_d   = '0;
        out_last_d  = 1'b0;
        if (bnd) begin
          if (!pend_vld_q) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = bnd_addr;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (wr_hit) corrupt_d = 1'b1;
        if (last_acc) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_idx_d   = '0;
          if (pend_vld_q) begin
            // The slot frees this cycle, so a coincident boundary refills it.
            state_d     = S_LOAD;
            start_d     = pend_addr_q;
            pend_vld_d  = bnd;
            pend_addr_d = bnd ? bnd_addr : pend_addr_q;
          end else if (bnd) begin
            state_d = S_LOAD;
            start_d = bnd_addr;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (accept) begin
            out_idx_d  = nxt_idx;
            out_last_d = (nxt_idx == LAST_IDX);
            out_data_d = mem[rd_addr];
          end
          if (bnd) begin
            if (!pend_vld_q) begin
              pend_vld_d  = 1'b1;
              pend_addr_d = bnd_addr;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_LOAD) && (state_q != S_LOAD)) corrupt_d = 1'b0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q        <= '0;
      fill_q      <= '0;
      hop_q       <= '0;
      state_q     <= S_IDLE;
      start_q     <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      corrupt_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      hop_q       <= hop_d;
      state_q     <= state_d;
      start_q     <= start_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      corrupt_q   <= corrupt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef MIC_FRAME_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Saturating count of dropped boundaries, in step with the overrun pulse.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 16'hFFFF)) ovr_cnt_d = ovr_cnt_q + 16'd1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ovr_cnt_q <= '0;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 16'h0000;
`endif

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;
  assign out_last    = out_last_q;
  assign out_corrupt = out_valid_q && out_last_q && corrupt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Testbench for mic_frame_buffer: two instances (HOP=16 and HOP=4, FRAME_LEN=16)
// share one stimulus stream; frames are collected per instance and compared
// against hand-computed expectations.
module tb_mic_frame_buffer;
  logic clk = 1'b0;
  logic rst_n, mic_valid, out_ready;
  logic signed [15:0] mic_sample;
  logic [1:0] ov, ol, oc, oo;
  logic [1:0][15:0] od, ocnt;
  logic [1:0][3:0] oi;

  mic_frame_buffer #(.SAMPLE_W(16), .FRAME_LEN(16), .HOP(16)) u_hop16 (
    .clk(clk), .rst_n(rst_n), .mic_valid(mic_valid), .mic_sample(mic_sample),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_idx(oi[0]),
    .out_last(ol[0]), .out_corrupt(oc[0]), .overrun(oo[0]), .overrun_cnt(ocnt[0]));

  mic_frame_buffer #(.SAMPLE_W(16), .FRAME_LEN(16), .HOP(4)) u_hop4 (
    .clk(clk), .rst_n(rst_n), .mic_valid(mic_valid), .mic_sample(mic_sample),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_idx(oi[1]),
    .out_last(ol[1]), .out_corrupt(oc[1]), .overrun(oo[1]), .overrun_cnt(ocnt[1]));

  always #5 clk = ~clk;

  typedef struct {
    int dut;   // 0: HOP=16 instance, 1: HOP=4 instance
    int per;   // mic_valid every per-th cycle
    int ncyc;  // cycles to run
    int fvc;   // cycle of first out_valid
    int s0, s1, s2;  // first sample of frames 0..2
    int ovr;   // 1 if overrun pulses expected
  } vec_t;

  vec_t tv [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, smp, d, first, exp_cnt;
  int nfr [2];
  int fvc [2];
  int novr [2];
  int prv [2];
  int bp [2];
  int cur_fs [2];
  bit cur_ok [2];
  int fs [2][8];
  bit fg [2][8];
  bit fc [2][8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      nfr[i] = 0; fvc[i] = -1; novr[i] = 0; prv[i] = 0; bp[i] = 0;
      cur_fs[i] = 0; cur_ok[i] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        fs[i][k] = -1; fg[i][k] = 1'b0; fc[i][k] = 1'b0;
      end
    end
  endtask

  // Records beats that will be accepted at the coming edge.
  task automatic capture();
    for (int i = 0; i < 2; i++) begin
      if (oo[i]) novr[i]++;
      if (ov[i] && fvc[i] < 0) fvc[i] = cyc;
      if (ov[i] && out_ready) begin
        if (oi[i] == 4'd0) begin
          cur_fs[i] = int'(od[i]);
          cur_ok[i] = 1'b1;
        end else if (int'(od[i]) != prv[i] + 1) begin
          cur_ok[i] = 1'b0;
        end
        if (int'(oi[i]) != bp[i]) cur_ok[i] = 1'b0;
        if (ol[i] != (oi[i] == 4'd15)) cur_ok[i] = 1'b0;
        if (ol[i]) begin
          if (nfr[i] < 8) begin
            fs[i][nfr[i]] = cur_fs[i];
            fg[i][nfr[i]] = cur_ok[i];
            fc[i][nfr[i]] = oc[i];
          end
          nfr[i]++;
        end
        prv[i] = int'(od[i]);
        bp[i]  = (int'(oi[i]) + 1) % 16;
      end
    end
  endtask

  task automatic cycle(input bit mv, input bit rdy, input bit rn);
    mic_valid  = mv;
    mic_sample = 16'(smp);
    out_ready  = rdy;
    rst_n      = rn;
    capture();
    @(posedge clk);
    #1;
    if (mv) smp++;
    cyc++;
  endtask

  task automatic start_scn();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cyc = 0;
    smp = 0;
    clear_mon();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached, got 0, expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{0, 1,  70, 17, 0, 16, 32, 0};
    tv[1] = '{1, 4, 115, 62, 0,  4,  8, 0};
    tv[2] = '{1, 1,  70, 17, 0,  4, 20, 1};

    rst_n = 1'b0; mic_valid = 1'b0; out_ready = 1'b1; mic_sample = '0;
    cyc = 0; smp = 0;
    clear_mon();

    // Reset state on both instances.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_valid", i), int'(ov[i]), 0);
      check($sformatf("rst%0d_data", i), int'(od[i]), 0);
      check($sformatf("rst%0d_idx", i), int'(oi[i]), 0);
      check($sformatf("rst%0d_last", i), int'(ol[i]), 0);
      check($sformatf("rst%0d_corrupt", i), int'(oc[i]), 0);
      check($sformatf("rst%0d_overrun", i), int'(oo[i]), 0);
      check($sformatf("rst%0d_ovrcnt", i), int'(ocnt[i]), 0);
    end

    // Table-driven framing scenarios with a free-running consumer.
    for (int i = 0; i < 3; i++) begin
      start_scn();
      for (int c = 0; c < tv[i].ncyc; c++) cycle((c % tv[i].per) == 0, 1'b1, 1'b1);
      d = tv[i].dut;
      check($sformatf("v%0d_first_valid_cycle", i), fvc[d], tv[i].fvc);
      check($sformatf("v%0d_frames_ge3", i), (nfr[d] >= 3) ? 1 : 0, 1);
      check($sformatf("v%0d_start0", i), fs[d][0], tv[i].s0);
      check($sformatf("v%0d_start1", i), fs[d][1], tv[i].s1);
      check($sformatf("v%0d_start2", i), fs[d][2], tv[i].s2);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("v%0d_frame%0d_consecutive", i, k), int'(fg[d][k]), 1);
        check($sformatf("v%0d_frame%0d_corrupt", i, k), int'(fc[d][k]), 0);
      end
      check($sformatf("v%0d_overrun_seen", i), (novr[d] > 0) ? 1 : 0, tv[i].ovr);
`ifdef MIC_FRAME_OVERRUN_CNT_EN
      exp_cnt = novr[d] + int'(oo[d]);
`else
      exp_cnt = 0;
`endif
      check($sformatf("v%0d_overrun_cnt", i), int'(ocnt[d]), exp_cnt);
    end

    // Consumer stalls 20 cycles on the first beat while samples keep arriving.
    start_scn();
    for (int c = 0; c < 65; c++) begin
      if (c >= 17 && c <= 36) begin
        check($sformatf("stall_valid_c%0d", c), int'(ov[0]), 1);
        check($sformatf("stall_data_c%0d", c), int'(od[0]), 0);
        check($sformatf("stall_idx_c%0d", c), int'(oi[0]), 0);
      end
      cycle(1'b1, !(c >= 17 && c <= 36), 1'b1);
    end
    check("stall_frames", (nfr[0] >= 1) ? 1 : 0, 1);
    check("stall_first_sample", fs[0][0], 0);
    check("stall_corrupt", int'(fc[0][0]), 1);
    check("stall_overrun_seen", (novr[0] > 0) ? 1 : 0, 1);

    // Boundary lands on the same cycle as the last-beat accept.
    start_scn();
    for (int c = 0; c < 55; c++) begin
      if (c == 32) check("coinc_last_beat", int'(ol[0]), 1);
      if (c == 33) check("coinc_load_gap", int'(ov[0]), 0);
      if (c == 34) begin
        check("coinc_first_valid", int'(ov[0]), 1);
        check("coinc_first_idx", int'(oi[0]), 0);
        check("coinc_first_data", int'(od[0]), 16);
      end
      cycle(c != 16, 1'b1, 1'b1);
    end
    check("coinc_frames", (nfr[0] >= 2) ? 1 : 0, 1);
    check("coinc_frame1_consecutive", int'(fg[0][1]), 1);
    check("coinc_frame1_corrupt", int'(fc[0][1]), 0);
    check("coinc_no_overrun", novr[0], 0);

    // One-cycle reset in the middle of a stream.
    start_scn();
    for (int c = 0; c < 20; c++) cycle(1'b1, 1'b1, 1'b1);
    check("mrst_streaming", int'(ov[0]), 1);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("mrst%0d_valid", i), int'(ov[i]), 0);
      check($sformatf("mrst%0d_data", i), int'(od[i]), 0);
      check($sformatf("mrst%0d_idx", i), int'(oi[i]), 0);
      check($sformatf("mrst%0d_last", i), int'(ol[i]), 0);
      check($sformatf("mrst%0d_corrupt", i), int'(oc[i]), 0);
      check($sformatf("mrst%0d_overrun", i), int'(oo[i]), 0);
    end
    first = smp;
    for (int c = 21; c < 38; c++) begin
      check($sformatf("mrst_quiet_c%0d", c), int'(ov[0]), 0);
      cycle(1'b1, 1'b1, 1'b1);
    end
    check("mrst_refill_valid", int'(ov[0]), 1);
    check("mrst_refill_idx", int'(oi[0]), 0);
    check("mrst_refill_data", int'(od[0]), first);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
